// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: access size codes, FSM
// state encoding, default bus watchdog limit and the store-side lane helpers.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    // Reserved size code 2'b11 is treated like a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr != 2'b00);
            default:   bad = (addr != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr;
            SIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes so the byte enables alone
    // pick which bytes land in memory.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            SIZE_BYTE: wd = {4{data[7:0]}};
            SIZE_HALF: wd = {2{data[15:0]}};
            SIZE_WORD: wd = data;
            default:   wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the addressed byte/half lane out of the bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select followed by extension according to size and signedness.
    always_comb begin
        lane_b = 8'h00;
        lane_h = 16'h0000;
        value  = rdata;
        case (addr)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: value = zero_ext ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            SIZE_HALF: value = zero_ext ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
            default:   value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns loads/stores into single-beat data-bus
// requests, aligns/extends load data and passes other results through.
// Optional bus watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
// state   | meaning
// ST_IDLE | no bus access outstanding
// ST_BUS  | request on the bus, waiting for i_mem_ack (upstream stalled)
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic        i_regWrite,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_regWrite,
    output logic [4:0]  o_rd,
    output logic        o_misalign,
    output logic        o_buserr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    state_t      state;

    // Controls of the outstanding bus access, needed again when the ack lands.
    logic [1:0]  pend_lane;
    logic [1:0]  pend_size;
    logic        pend_zext;
    logic        pend_load;
    logic        pend_regwrite;
    logic [4:0]  pend_rd;

    // One-entry holding slot: a non-bus instruction accepted on the same edge
    // as a bus completion cannot share the output cycle, so it waits here and
    // every following back-to-back non-bus result flows through it in order.
    logic        sk_valid;
    logic [31:0] sk_result;
    logic        sk_regwrite;
    logic [4:0]  sk_rd;
    logic        sk_misalign;

    logic        accept;
    logic        is_mem;
    logic        mis;
    logic        mem_go;
    logic        direct;
    logic [31:0] direct_result;
    logic        direct_regwrite;
    logic        mem_done;
    logic        wd_fire;
    logic        finish;
    logic [31:0] load_value;

    assign o_stall         = (state == ST_BUS) & ~i_mem_ack;
    assign accept          = i_valid & ~o_stall;
    assign is_mem          = i_memRead | i_memWrite;
    assign mis             = is_mem & is_misaligned(i_size, i_ALUres[1:0]);
    assign mem_go          = accept & is_mem & ~mis;
    assign direct          = accept & ~mem_go;
    assign direct_result   = mis ? 32'h0000_0000 : i_ALUres;
    assign direct_regwrite = i_regWrite & ~mis;
    assign mem_done        = (state == ST_BUS) & i_mem_ack;
    assign finish          = mem_done | wd_fire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog down-counter: reloaded when a bus access is accepted, fires at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
        end else if (mem_go) begin
            wd_cnt <= WD_RELOAD;
        end else if ((state == ST_BUS) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    // An ack in the terminal cycle masks the abort.
    assign wd_fire = (state == ST_BUS) & ~i_mem_ack & (wd_cnt == '0);
`else
    assign wd_fire = 1'b0;
`endif

    load_align u_load_align (
        .rdata    (i_mem_rdata),
        .addr     (pend_lane),
        .size     (pend_size),
        .zero_ext (pend_zext),
        .value    (load_value)
    );

    // Stage FSM, bus request registers and writeback output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_regWrite    <= 1'b0;
            o_rd          <= '0;
            o_misalign    <= 1'b0;
            o_buserr      <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_mem_be      <= '0;
            pend_lane     <= '0;
            pend_size     <= '0;
            pend_zext     <= 1'b0;
            pend_load     <= 1'b0;
            pend_regwrite <= 1'b0;
            pend_rd       <= '0;
            sk_valid      <= 1'b0;
            sk_result     <= '0;
            sk_regwrite   <= 1'b0;
            sk_rd         <= '0;
            sk_misalign   <= 1'b0;
        end else begin
            o_valid    <= 1'b0;
            o_misalign <= 1'b0;
            o_buserr   <= 1'b0;

            if (finish) begin
                // Bus completion (ack or watchdog abort) owns the output slot.
                o_valid    <= 1'b1;
                o_result   <= (mem_done & pend_load) ? load_value : 32'h0000_0000;
                o_regWrite <= mem_done & pend_regwrite;
                o_rd       <= pend_rd;
                o_buserr   <= ~mem_done;
                o_mem_req  <= 1'b0;
                o_mem_we   <= 1'b0;
                state      <= ST_IDLE;
                if (direct) begin
                    sk_valid    <= 1'b1;
                    sk_result   <= direct_result;
                    sk_regwrite <= direct_regwrite;
                    sk_rd       <= i_rd;
                    sk_misalign <= mis;
                end
            end else if (sk_valid) begin
                o_valid     <= 1'b1;
                o_result    <= sk_result;
                o_regWrite  <= sk_regwrite;
                o_rd        <= sk_rd;
                o_misalign  <= sk_misalign;
                sk_valid    <= direct;
                sk_result   <= direct_result;
                sk_regwrite <= direct_regwrite;
                sk_rd       <= i_rd;
                sk_misalign <= mis;
            end else if (direct) begin
                o_valid    <= 1'b1;
                o_result   <= direct_result;
                o_regWrite <= direct_regwrite;
                o_rd       <= i_rd;
                o_misalign <= mis;
            end

            if (mem_go) begin
                state         <= ST_BUS;
                o_mem_req     <= 1'b1;
                o_mem_we      <= i_memWrite;
                o_mem_addr    <= {i_ALUres[31:2], 2'b00};
                o_mem_be      <= byte_enable(i_size, i_ALUres[1:0]);
                o_mem_wdata   <= store_data(i_size, i_op2);
                pend_lane     <= i_ALUres[1:0];
                pend_size     <= i_size;
                pend_zext     <= i_unsigned;
                pend_load     <= i_memRead & ~i_memWrite;
                pend_regwrite <= i_regWrite;
                pend_rd       <= i_rd;
            end
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the pipelined MIPS core, the consumer of the execute stage's ALU result and forwarded second operand. It turns load/store instructions into single-beat requests on the data-memory bus, aligns and extends load data, and passes non-memory results straight through to writeback. It owns the data-memory handshake and raises a stall toward the earlier stages while a bus access is outstanding.

## Interface
- TIMEOUT_CYCLES, 256, bus-ack watchdog limit in cycles; used only with MEM_ACCESS_TIMEOUT_EN.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  instruction present from execute.
- i_ALUres  input  32  ALU result; byte address for loads and stores.
- i_op2  input  32  store data.
- i_memRead / i_memWrite  input  1 each  load / store; both low means pass-through.
- i_size  input  2  access size: 00 byte, 01 half, 10 word.
- i_unsigned  input  1  zero-extend loads (lbu/lhu) instead of sign-extending.
- i_regWrite  input  1, i_rd  input  5  writeback control, carried through.
- o_stall  output  1  upstream must hold its outputs.
- o_valid  output  1  result valid toward writeback, 1-cycle pulse per instruction.
- o_result  output  32  load data or passed ALU result.
- o_regWrite  output  1, o_rd  output  5  carried writeback control.
- o_misalign  output  1  alignment fault, qualified by o_valid.
- o_buserr  output  1  watchdog abort, qualified by o_valid.
- o_mem_req  output  1, o_mem_we  output  1  bus request and write strobe.
- o_mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- o_mem_wdata  output  32, o_mem_be  output  4  write data and byte enables.
- i_mem_ack  input  1, i_mem_rdata  input  32  bus acknowledge and read data.

## Operation
- States: IDLE, BUS.
- o_stall = (state==BUS) & ~i_mem_ack, combinational.
- Accept: any rising edge with i_valid & ~o_stall. Inputs are not sampled on any other edge.
- Pass-through accept (no read or write):
  - next cycle o_valid=1, o_result=i_ALUres, o_misalign=0.
  - state unchanged, or IDLE if accepted from BUS.
- Misaligned accept (half with addr[0]=1, word with addr[1:0]!=0):
  - no bus request.
  - next cycle o_valid=1, o_misalign=1, o_result=0, o_regWrite=0.
- Aligned memory accept:
  - register address, be, wdata, load controls.
  - go to BUS; o_mem_req=1 from the next cycle and held with all bus outputs stable until i_mem_ack.
- Byte enables, little-endian:
  - byte: be=1<<addr[1:0].
  - half: 0011 or 1100.
  - word: 1111.
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load: on ack, select the lane by addr[1:0], then sign- or zero-extend per i_unsigned. Stores give o_result=0.
- BUS & i_mem_ack: o_mem_req drops next cycle and o_valid pulses next cycle. A new instruction accepted on the same edge may go straight back to BUS, giving back-to-back requests with no gap.

## Timing
- Reset values: state=IDLE; all outputs 0; o_stall=0.
- Reset mid-access drops o_mem_req asynchronously and discards the instruction. A late ack after reset is ignored.
- Latency:
  - pass-through and misalign: accept edge +1.
  - memory: o_mem_req at accept+1; o_valid on the cycle after the ack cycle.
  - minimum load latency is 2 cycles when ack arrives in the first request cycle.
- i_mem_ack outside BUS is ignored.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - a counter runs in BUS and clears on accept.
  - if TIMEOUT_CYCLES cycles pass without ack: drop the request, o_valid=1, o_buserr=1, o_regWrite=0, return to IDLE.
  - an ack in the same cycle as the timeout wins.
- Undefined: BUS waits indefinitely, o_buserr tied 0, no counter logic.

## Structure
- Shared package mem_access_pkg holds:
  - size codes SIZE_BYTE / SIZE_HALF / SIZE_WORD.
  - state encoding ST_IDLE / ST_BUS.
  - default TIMEOUT_CYCLES.
- One combinational sub-module load_align: (rdata, addr[1:0], size, unsigned) → 32-bit extended load value.

## Test plan
- lb at addr 0x103, rdata 0x80FFFFFF, ack on first request cycle → o_mem_be=1000, o_result 0xFFFFFF80 two cycles after accept. Same access as lbu → 0x00000080.
- sh at addr 0x202, op2 0x0000BEEF → o_mem_be=1100, o_mem_wdata 0xBEEFBEEF, o_mem_addr 0x200, o_stall high until ack.
- lw at addr 0x06 → no o_mem_req, o_valid with o_misalign=1, o_regWrite=0.
- lw with ack delayed 5 cycles, then a pass-through add (ALUres 42) presented during the stall → add held; add's o_valid with result 42 one cycle after the load's o_valid.
- Two back-to-back sw, both acked immediately → o_mem_req stays high across both with no gap.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → o_buserr pulse after 4 request cycles. Separately, reset asserted mid-BUS → o_mem_req low immediately.
